wb_reg_bank: RTL
================

// Module: wb_reg_bank
// PURPOSE
//  Parametrised Wishbone classic slave register bank for the video_in control path.
//  Decodes NREG word registers at BASE_ADDR; adds readback, byte-lane writes, read-only status regs,
//  self-clearing pulse regs, per-register write strobes and ERR on out-of-range access.
//  Sits between the WB interconnect and video_in control/status logic.
// PARAMETERS
//  BASE_ADDR   32'hb0000000   byte address of register 0 (must be 4*NREG aligned)
//  NREG        8              number of 32-bit registers, 1..64
//  PULSE_MASK  'hAA           bit i=1: reg i self-clears one cycle after write (control pulses)
//  RO_MASK     'h00           bit i=1: reg i is read-only; reads return p_ro_i slice i
//  RESET_VAL   32'h0          reset/clear value of every writable register
// PORTS
//  p_clk        in   1         clock, all logic on rising edge
//  p_reset      in   1         synchronous reset, active-high
//  p_wb_DAT_I   in   32        write data
//  p_wb_DAT_O   out  32        read data, valid while p_wb_ACK_O=1
//  p_wb_ADR_I   in   32        byte address
//  p_wb_ACK_O   out  1         normal termination
//  p_wb_CYC_I   in   1         bus cycle
//  p_wb_ERR_O   out  1         error termination (address miss/misaligned)
//  p_wb_LOCK_I  in   1         ignored
//  p_wb_RTY_O   out  1         tied 0
//  p_wb_SEL_I   in   4         byte lane enables
//  p_wb_STB_I   in   1         strobe
//  p_wb_WE_I    in   1         1=write 0=read
//  p_regs_o     out  32*NREG   register contents, reg i at [32*i +: 32]
//  p_wr_pulse_o out  NREG      1-cycle strobe: reg i written
//  p_ro_i       in   32*NREG   status inputs; only slices with RO_MASK bit set used
// BEHAVIOUR
//  Reset: state IDLE; ACK_O=ERR_O=RTY_O=0; DAT_O=0; all regs=RESET_VAL; p_wr_pulse_o=0.
//  FSM IDLE/RESP. IDLE & CYC_I & STB_I -> RESP (request sampled at that edge); RESP -> IDLE always.
//  ACK/ERR registered: asserted for exactly the one RESP cycle, latency 1; back-to-back requests
//   therefore complete every 2 cycles; STB held through RESP is not re-acked.
//  Hit: ADR_I in [BASE_ADDR, BASE_ADDR+4*NREG) and ADR_I[1:0]==0; idx=(ADR_I-BASE_ADDR)>>2,
//   width $clog2(NREG), compute offset in 32 bits (no wrap: ADR_I<BASE_ADDR is a miss).
//  Miss: ERR_O=1, ACK_O=0, no state change, DAT_O=0.
//  Write hit: on IDLE->RESP edge, byte k of reg idx <= DAT_I byte k iff SEL_I[k]; SEL_I=0 -> ack, no change.
//   p_wr_pulse_o[idx]=1 during RESP (same cycle as ACK). RO reg: acked, data and strobe suppressed.
//  Pulse reg (PULSE_MASK): written value visible on p_regs_o for exactly the RESP cycle, then
//   returns to RESET_VAL on next edge; unwritten pulse regs stay RESET_VAL.
//  Read hit: DAT_O = reg idx (or p_ro_i slice if RO), captured at IDLE->RESP edge, all 32 bits
//   regardless of SEL_I; pulse regs read RESET_VAL. DAT_O=0 outside ACK cycles.
//  CYC_I/STB_I dropped during RESP: termination still issued for that cycle, write already committed.
//  p_reset during RESP: next edge IDLE, ACK/ERR=0, regs to RESET_VAL; pending transfer lost.
// STRUCTURE
//  Package wb_pkg: typedef enum {WB_IDLE, WB_RESP} wb_state_t; WB_AW=32, WB_DW=32, WB_SELW=4;
//   function wb_merge(old,new,sel) for byte-lane merge.
//  Sub-module wb_addr_decode (comb): ADR_I -> hit, idx; parametrised by BASE_ADDR, NREG.
//  Top: FSM, register array, pulse clear, read mux, output regs.
// TESTING
//  Reset then read all 8 regs -> each ACK 1 cycle after STB, DAT_O=0, ERR_O=0.
//  Write 0xDEADBEEF to 0xb0000000 SEL=4'b0101 then read -> 0x00AD00EF; p_wr_pulse_o[0] 1 cycle.
//  Write 0x1 to 0xb0000004 (reg1, pulse) -> p_regs_o[63:32]=1 only in ACK cycle, 0 after; read=0.
//  Access 0xb0000020, 0xafffFFFC, 0xb0000002 -> ERR_O=1 one cycle, ACK_O=0, regs unchanged.
//  RO_MASK=8'h04, p_ro_i reg2=0x12345678: write 0xFFFFFFFF to 0xb0000008 -> ACK, no strobe; read=0x12345678.
//  STB held 6 cycles -> ACK pattern 0,1,0,1,0,1; assert p_reset in a RESP cycle -> ACK 0 next cycle, regs cleared.

Source files
------------

// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg: shared Wishbone widths, slave FSM states and byte-lane merge helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wb_pkg;
  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_RESP = 1'b1
  } wb_state_t;

  function automatic logic [WB_DW-1:0] wb_merge(
    input logic [WB_DW-1:0]   old_v,
    input logic [WB_DW-1:0]   new_v,
    input logic [WB_SELW-1:0] sel
  );
    logic [WB_DW-1:0] res;
    res = old_v;
    for (int k = 0; k < WB_SELW; k++) begin
      if (sel[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction
endpackage

`default_nettype wire

// File: rtl/wb_addr_decode.sv
// ----------------------------------------------------------------------------
// wb_addr_decode: maps a byte address onto a register index of the bank.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_addr_decode
  import wb_pkg::*;
#(
  parameter logic [WB_AW-1:0] BASE_ADDR = 32'hb0000000,
  parameter int               NREG      = 8,
  parameter int               IDXW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic [WB_AW-1:0] adr_i,
  output logic             hit_o,
  output logic [IDXW-1:0]  idx_o
);
  logic [WB_AW-1:0] offset;
  logic             unused_offset;

  // Offset is unsigned 32-bit, so addresses below the base are rejected explicitly.
  always_comb begin
    offset = adr_i - BASE_ADDR;
    hit_o  = (adr_i >= BASE_ADDR) && (offset < WB_AW'(4 * NREG)) && (adr_i[1:0] == 2'b00);
    idx_o  = offset[IDXW+1:2];
  end

  assign unused_offset = ^{offset[WB_AW-1:IDXW+2], offset[1:0]};
endmodule

`default_nettype wire

// File: rtl/wb_reg_bank.sv
// ----------------------------------------------------------------------------
// wb_reg_bank: Wishbone classic slave register bank for the video_in control path.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_reg_bank
  import wb_pkg::*;
#(
  parameter logic [WB_AW-1:0] BASE_ADDR  = 32'hb0000000,
  parameter int               NREG       = 8,
  parameter logic [63:0]      PULSE_MASK = 64'hAA,
  parameter logic [63:0]      RO_MASK    = 64'h00,
  parameter logic [WB_DW-1:0] RESET_VAL  = 32'h0
) (
  input  logic                  p_clk,
  input  logic                  p_reset,
  input  logic [WB_DW-1:0]      p_wb_DAT_I,
  output logic [WB_DW-1:0]      p_wb_DAT_O,
  input  logic [WB_AW-1:0]      p_wb_ADR_I,
  output logic                  p_wb_ACK_O,
  input  logic                  p_wb_CYC_I,
  output logic                  p_wb_ERR_O,
  input  logic                  p_wb_LOCK_I,
  output logic                  p_wb_RTY_O,
  input  logic [WB_SELW-1:0]    p_wb_SEL_I,
  input  logic                  p_wb_STB_I,
  input  logic                  p_wb_WE_I,
  output logic [WB_DW*NREG-1:0] p_regs_o,
  output logic [NREG-1:0]       p_wr_pulse_o,
  input  logic [WB_DW*NREG-1:0] p_ro_i
);
  localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;

  wb_state_t        state_q, state_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [WB_DW-1:0] dat_q, dat_d;
  logic [NREG-1:0]  wr_pulse_q, wr_pulse_d;
  logic [WB_DW-1:0] regs_q [NREG];
  logic [WB_DW-1:0] regs_d [NREG];
  logic [WB_DW-1:0] cur_val;
  logic             hit;
  logic [IDXW-1:0]  idx;
  logic             unused_lock;

  wb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NREG      (NREG),
    .IDXW      (IDXW)
  ) u_decode (
    .adr_i (p_wb_ADR_I),
    .hit_o (hit),
    .idx_o (idx)
  );

  always_comb begin
    state_d    = WB_IDLE;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = '0;
    wr_pulse_d = '0;
    cur_val    = '0;
    // Pulse registers only hold a written value for the single response cycle.
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = PULSE_MASK[i] ? RESET_VAL : regs_q[i];
    end

    if ((state_q == WB_IDLE) && p_wb_CYC_I && p_wb_STB_I) begin
      state_d = WB_RESP;
      if (hit) begin
        ack_d   = 1'b1;
        cur_val = PULSE_MASK[idx] ? RESET_VAL : regs_q[idx];
        if (p_wb_WE_I) begin
          if (!RO_MASK[idx]) begin
            regs_d[idx]     = wb_merge(cur_val, p_wb_DAT_I, p_wb_SEL_I);
            wr_pulse_d[idx] = 1'b1;
          end
        end else begin
          dat_d = RO_MASK[idx] ? p_ro_i[WB_DW*idx +: WB_DW] : cur_val;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_q    <= WB_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs_out
    assign p_regs_o[WB_DW*g +: WB_DW] = regs_q[g];
  end

  assign p_wb_ACK_O   = ack_q;
  assign p_wb_ERR_O   = err_q;
  assign p_wb_RTY_O   = 1'b0;
  assign p_wb_DAT_O   = dat_q;
  assign p_wr_pulse_o = wr_pulse_q;
  assign unused_lock  = p_wb_LOCK_I;
endmodule

`default_nettype wire
